// File: rtl/ibus_arbiter.sv
// Two-requester instruction-bus arbiter: round-robin command grant with hold-until-accept,
// in-order route FIFO for response steering, and an outstanding-transaction cap.
module ibus_arbiter #(
    parameter int unsigned ADDR_W  = 64,
    parameter int unsigned DATA_W  = 64,
    parameter int unsigned ID_W    = 16,
    parameter int unsigned MAX_OUT = 4
) (
    input  logic                         io_clk,
    input  logic                         io_reset,
    input  logic                         m0_cmd_valid,
    output logic                         m0_cmd_ready,
    input  logic [ADDR_W-1:0]            m0_cmd_address,
    input  logic [ID_W-1:0]              m0_cmd_id,
    output logic                         m0_rsp_valid,
    output logic [DATA_W-1:0]            m0_rsp_data,
    output logic [ADDR_W-1:0]            m0_rsp_address,
    output logic [ID_W-1:0]              m0_rsp_id,
    input  logic                         m1_cmd_valid,
    output logic                         m1_cmd_ready,
    input  logic [ADDR_W-1:0]            m1_cmd_address,
    input  logic [ID_W-1:0]              m1_cmd_id,
    output logic                         m1_rsp_valid,
    output logic [DATA_W-1:0]            m1_rsp_data,
    output logic [ADDR_W-1:0]            m1_rsp_address,
    output logic [ID_W-1:0]              m1_rsp_id,
    output logic                         s_cmd_valid,
    input  logic                         s_cmd_ready,
    output logic [ADDR_W-1:0]            s_cmd_address,
    output logic [ID_W-1:0]              s_cmd_id,
    input  logic                         s_rsp_valid,
    input  logic [DATA_W-1:0]            s_rsp_data,
    input  logic [ADDR_W-1:0]            s_rsp_address,
    input  logic [ID_W-1:0]              s_rsp_id,
    output logic [$clog2(MAX_OUT):0]     outstanding,
    output logic                         err
);
    localparam int unsigned PTR_W = $clog2(MAX_OUT);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t             state_q, state_d;
    logic               lock_src_q, lock_src_d;
    logic               rr_last_q;
    logic               space, gnt_valid, gnt_src, push, pop, cmd_err, rsp_err;
    logic               head_src;
    logic [ID_W-1:0]    head_id;
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]   count_q;
    logic               fifo_src_q [MAX_OUT];
    logic [ID_W-1:0]    fifo_id_q  [MAX_OUT];

    assign space = (count_q < CNT_W'(MAX_OUT));

    // Grant selection and IDLE/LOCKED next state
    always_comb begin
        state_d    = state_q;
        lock_src_d = lock_src_q;
        gnt_valid  = 1'b0;
        gnt_src    = 1'b0;
        cmd_err    = 1'b0;
        case (state_q)
            IDLE: begin
                if (!io_reset && space) begin
                    if (m0_cmd_valid && m1_cmd_valid) begin
                        gnt_valid = 1'b1;
                        gnt_src   = ~rr_last_q;
                    end else if (m0_cmd_valid) begin
                        gnt_valid = 1'b1;
                        gnt_src   = 1'b0;
                    end else if (m1_cmd_valid) begin
                        gnt_valid = 1'b1;
                        gnt_src   = 1'b1;
                    end
                    if (gnt_valid && !s_cmd_ready) begin
                        state_d    = LOCKED;
                        lock_src_d = gnt_src;
                    end
                end
            end
            LOCKED: begin
                gnt_src   = lock_src_q;
                gnt_valid = lock_src_q ? m1_cmd_valid : m0_cmd_valid;
                if (!gnt_valid) begin
                    cmd_err = 1'b1;
                    state_d = IDLE;
                end else if (s_cmd_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign push          = gnt_valid && s_cmd_ready;
    assign s_cmd_valid   = gnt_valid;
    assign s_cmd_address = gnt_src ? m1_cmd_address : m0_cmd_address;
    assign s_cmd_id      = gnt_src ? m1_cmd_id : m0_cmd_id;
    assign m0_cmd_ready  = push && !gnt_src;
    assign m1_cmd_ready  = push && gnt_src;

    assign head_src = fifo_src_q[rd_ptr_q];
    assign head_id  = fifo_id_q[rd_ptr_q];
    assign pop      = s_rsp_valid && (count_q != '0);
    assign rsp_err  = s_rsp_valid && ((count_q == '0) || (s_rsp_id != head_id));
    assign outstanding = count_q;

    // Route FIFO storage; validity is tracked by the pointers and count
    always_ff @(posedge io_clk) begin
        if (push) begin
            fifo_src_q[wr_ptr_q] <= gnt_src;
            fifo_id_q[wr_ptr_q]  <= s_cmd_id;
        end
    end

    always_ff @(posedge io_clk or posedge io_reset) begin
        if (io_reset) begin
            state_q        <= IDLE;
            lock_src_q     <= 1'b0;
            rr_last_q      <= 1'b1;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            err            <= 1'b0;
            m0_rsp_valid   <= 1'b0;
            m0_rsp_data    <= '0;
            m0_rsp_address <= '0;
            m0_rsp_id      <= '0;
            m1_rsp_valid   <= 1'b0;
            m1_rsp_data    <= '0;
            m1_rsp_address <= '0;
            m1_rsp_id      <= '0;
        end else begin
            state_q    <= state_d;
            lock_src_q <= lock_src_d;
            if (push) begin
                rr_last_q <= gnt_src;
                wr_ptr_q  <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
            if (cmd_err || rsp_err) begin
                err <= 1'b1;
            end
            // Responses always carry the id recorded at issue
            m0_rsp_valid <= pop && !head_src;
            m1_rsp_valid <= pop && head_src;
            if (pop && !head_src) begin
                m0_rsp_data    <= s_rsp_data;
                m0_rsp_address <= s_rsp_address;
                m0_rsp_id      <= head_id;
            end
            if (pop && head_src) begin
                m1_rsp_data    <= s_rsp_data;
                m1_rsp_address <= s_rsp_address;
                m1_rsp_id      <= head_id;
            end
        end
    end
endmodule
